// File: rtl/icache_line_fill.sv
`default_nettype none
// ============================================================================
// icache_line_fill : direct-mapped read-only L1 I-cache, one line load per miss
// Optional flush ports with `define ICACHE_FLUSH_EN.           Revision: 1.0
// ============================================================================
module icache_line_fill #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int CHUNKS_LOG = 3,
  parameter int SETS_LOG   = 6
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  req_valid,
  input  logic [ADDR_WIDTH-1:0]                 req_addr,
  output logic                                  req_ready,
  output logic                                  resp_valid,
  output logic [DATA_WIDTH-1:0]                 resp_data,
  input  logic                                  resp_ready,
  output logic                                  command_valid,
  output logic                                  command_store,
  output logic                                  command_rready,
  output logic [ADDR_WIDTH-1:0]                 command_addr,
  output logic [DATA_WIDTH*(2**CHUNKS_LOG)-1:0] data_in,
  input  logic                                  bus_valid,
  input  logic                                  bus_ready,
  input  logic [DATA_WIDTH*(2**CHUNKS_LOG)-1:0] data_out
`ifdef ICACHE_FLUSH_EN
  ,
  input  logic                                  flush_req,
  output logic                                  flush_done
`endif
);
  localparam int C_OFF_W   = $clog2(DATA_WIDTH/8);
  localparam int C_WADDR_W = ADDR_WIDTH - C_OFF_W;
  localparam int C_TAG_W   = C_WADDR_W - CHUNKS_LOG - SETS_LOG;
  localparam int C_SETS    = 2**SETS_LOG;
  localparam int C_LINE_W  = DATA_WIDTH * (2**CHUNKS_LOG);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_MISS_REQ  = 3'd2,
    S_MISS_WAIT = 3'd3,
    S_RESP      = 3'd4,
    S_FLUSH     = 3'd5
  } state_t;

  state_t                 r_state;
  logic [C_WADDR_W-1:0]   r_waddr;
  logic                   r_req_ready;
  logic                   r_resp_valid;
  logic                   r_cmd_valid;
  logic                   r_cmd_rready;
  logic [ADDR_WIDTH-1:0]  r_cmd_addr;
  logic [DATA_WIDTH-1:0]  r_resp_data;
  logic [C_SETS-1:0]      r_valid;
  logic [C_TAG_W-1:0]     r_tag  [C_SETS];
  logic [C_LINE_W-1:0]    r_line [C_SETS];

  logic [CHUNKS_LOG-1:0]  w_word;
  logic [SETS_LOG-1:0]    w_set;
  logic [C_TAG_W-1:0]     w_tag;
  logic                   w_hit;
  logic                   w_accept;
  logic                   w_fill;
  logic [DATA_WIDTH-1:0]  w_hit_word;
  logic [DATA_WIDTH-1:0]  w_fill_word;
  logic                   w_unused_offset;

  // Only the word address is kept; byte-offset bits never influence a fetch.
  assign w_unused_offset = ^req_addr[C_OFF_W-1:0];

  assign w_word      = r_waddr[CHUNKS_LOG-1:0];
  assign w_set       = r_waddr[CHUNKS_LOG +: SETS_LOG];
  assign w_tag       = r_waddr[C_WADDR_W-1 -: C_TAG_W];
  assign w_hit       = r_valid[w_set] && (r_tag[w_set] == w_tag);
  assign w_hit_word  = r_line[w_set][w_word*DATA_WIDTH +: DATA_WIDTH];
  assign w_fill_word = data_out[w_word*DATA_WIDTH +: DATA_WIDTH];
  assign w_fill      = (r_state == S_MISS_WAIT) && bus_valid;

`ifdef ICACHE_FLUSH_EN
  logic r_flush_done;
  // A pending flush wins over a fetch in the same IDLE cycle.
  assign req_ready  = r_req_ready && !flush_req;
  assign flush_done = r_flush_done;
`else
  assign req_ready  = r_req_ready;
`endif

  assign w_accept       = req_valid && req_ready;
  assign resp_valid     = r_resp_valid;
  assign resp_data      = r_resp_data;
  assign command_valid  = r_cmd_valid;
  assign command_rready = r_cmd_rready;
  assign command_addr   = r_cmd_addr;
  assign command_store  = 1'b0;
  assign data_in        = '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_waddr      <= '0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_cmd_valid  <= 1'b0;
      r_cmd_rready <= 1'b0;
      r_cmd_addr   <= '0;
      r_resp_data  <= '0;
`ifdef ICACHE_FLUSH_EN
      r_flush_done <= 1'b0;
`endif
    end else begin
`ifdef ICACHE_FLUSH_EN
      r_flush_done <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
`ifdef ICACHE_FLUSH_EN
          if (flush_req) begin
            r_req_ready  <= 1'b0;
            r_valid      <= '0;
            r_flush_done <= 1'b1;
            r_state      <= S_FLUSH;
          end else
`endif
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_waddr     <= req_addr[ADDR_WIDTH-1:C_OFF_W];
            r_state     <= S_LOOKUP;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            r_resp_data  <= w_hit_word;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_cmd_addr  <= {r_waddr[C_WADDR_W-1:CHUNKS_LOG], {(CHUNKS_LOG+C_OFF_W){1'b0}}};
            r_cmd_valid <= 1'b1;
            r_state     <= S_MISS_REQ;
          end
        end
        S_MISS_REQ: begin
          if (bus_ready) begin
            r_cmd_valid  <= 1'b0;
            r_cmd_rready <= 1'b1;
            r_state      <= S_MISS_WAIT;
          end
        end
        S_MISS_WAIT: begin
          if (bus_valid) begin
            r_valid[w_set] <= 1'b1;
            r_resp_data    <= w_fill_word;
            r_cmd_rready   <= 1'b0;
            r_resp_valid   <= 1'b1;
            r_state        <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        S_FLUSH: begin
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Gated by reset so a line arriving in the reset cycle is never installed.
  always_ff @(posedge clk) begin
    if (reset && w_fill) begin
      r_tag[w_set]  <= w_tag;
      r_line[w_set] <= data_out;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_line_fill.sv
`default_nettype none
// Bench for icache_line_fill: directed scenarios plus randomized fetches
// checked against an address-arithmetic cache model and a memory scoreboard.
module tb_icache_line_fill;
  localparam int LW = 512;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic [63:0]   req_addr = '0;
  logic          req_ready;
  logic          resp_valid;
  logic [63:0]   resp_data;
  logic          resp_ready = 1'b1;
  logic          command_valid;
  logic          command_store;
  logic          command_rready;
  logic [63:0]   command_addr;
  logic [LW-1:0] data_in;
  logic          bus_valid = 1'b0;
  logic          bus_ready = 1'b0;
  logic [LW-1:0] data_out = '0;
`ifdef ICACHE_FLUSH_EN
  logic          flush_req = 1'b0;
  logic          flush_done;
`endif

  int checks = 0;
  int errors = 0;

  logic [LW-1:0] mem [logic [63:0]];
  bit            ref_valid [64];
  logic [63:0]   ref_tag   [64];

  icache_line_fill dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
    .command_valid(command_valid), .command_store(command_store),
    .command_rready(command_rready), .command_addr(command_addr),
    .data_in(data_in), .bus_valid(bus_valid), .bus_ready(bus_ready),
    .data_out(data_out)
`ifdef ICACHE_FLUSH_EN
    , .flush_req(flush_req), .flush_done(flush_done)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [LW-1:0] line_of(input logic [63:0] la);
    logic [LW-1:0] v;
    if (!mem.exists(la)) begin
      for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
      mem[la] = v;
    end
    return mem[la];
  endfunction

  function automatic void set_line(input logic [63:0] la, input logic [63:0] base);
    logic [LW-1:0] v;
    for (int k = 0; k < 8; k++) v[k*64 +: 64] = base + 64'(k);
    mem[la] = v;
  endfunction

  function automatic logic [63:0] exp_word(input logic [63:0] a);
    logic [LW-1:0] l;
    int w;
    l = line_of(a & ~64'h3F);
    w = int'((a >> 3) % 8);
    return l[w*64 +: 64];
  endfunction

  // Returns 1 when the access misses, then records the line as resident.
  function automatic bit model_access(input logic [63:0] a);
    int s;
    bit miss;
    s = int'((a >> 6) % 64);
    miss = !(ref_valid[s] && ref_tag[s] == (a >> 12));
    ref_valid[s] = 1'b1;
    ref_tag[s]   = a >> 12;
    return miss;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < 64; s++) ref_valid[s] = 1'b0;
  endfunction

  task automatic do_fetch(input logic [63:0] a, input int cd, input int rd,
                          output logic [63:0] data, output int lat, output bit missed,
                          output logic [63:0] caddr, output bit bad, output bit store_seen);
    int c, wc, rc, k;
    bit got;
    data = '0; lat = -1; missed = 0; caddr = '0; bad = 0; store_seen = 0;
    got = 0; wc = 0; rc = 0; k = 0;
    while (req_ready !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    if (req_ready !== 1'b1) begin bad = 1; return; end
    req_valid = 1'b1; req_addr = a; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = {$urandom, $urandom};
    c = 1;
    while (!got && c < 300) begin
      if (command_store !== 1'b0 || data_in !== '0) store_seen = 1;
      if (command_valid === 1'b1) begin
        if (!missed) begin missed = 1; caddr = command_addr; end
        bus_ready = (wc == cd);
        wc++;
      end else begin
        bus_ready = 1'($urandom);
      end
      if (command_rready === 1'b1) begin
        if (rc == rd) begin bus_valid = 1'b1; data_out = line_of(caddr); end
        else begin bus_valid = 1'b0; data_out = {16{$urandom}}; end
        rc++;
      end else begin
        bus_valid = 1'($urandom);
        data_out  = {16{$urandom}};
      end
      if (resp_valid === 1'b1) begin got = 1; lat = c; data = resp_data; end
      @(posedge clk); #1;
      c++;
    end
    bus_valid = 1'b0; bus_ready = 1'b0;
    if (!got) bad = 1;
  endtask

  task automatic test_reset();
    int k;
    reset = 1'b0; req_valid = 1'b1; req_addr = 64'h1000;
    bus_valid = 1'b1; bus_ready = 1'b1; data_out = {16{$urandom}};
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (command_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %b expected 0", command_valid); end
    checks++; if (command_rready !== 1'b0) begin errors++; $display("FAIL reset_cmd_rready: got %b expected 0", command_rready); end
    checks++; if (command_addr !== 64'h0) begin errors++; $display("FAIL reset_cmd_addr: got %h expected 0", command_addr); end
    checks++; if (resp_data !== 64'h0) begin errors++; $display("FAIL reset_resp_data: got %h expected 0", resp_data); end
    checks++; if (command_store !== 1'b0 || data_in !== '0) begin errors++; $display("FAIL reset_store: got store=%b data_in_nonzero=%b expected 0", command_store, |data_in); end
    req_valid = 1'b0; bus_valid = 1'b0; bus_ready = 1'b0; reset = 1'b1;
    model_clear();
    k = 0;
    while (req_ready !== 1'b1 && k < 3) begin @(posedge clk); #1; k++; end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_cold_miss();
    logic [63:0] d, ca; int lat; bit m, bad, ss, em;
    set_line(64'h1000, 64'hA0);
    em = model_access(64'h1008);
    do_fetch(64'h1008, 3, 0, d, lat, m, ca, bad, ss);
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL cold_timeout: got %b expected 0", bad); end
    checks++; if (m !== em) begin errors++; $display("FAIL cold_miss: got %b expected %b", m, em); end
    checks++; if (ca !== 64'h1000) begin errors++; $display("FAIL cold_caddr: got %h expected 1000", ca); end
    checks++; if (d !== 64'hA1) begin errors++; $display("FAIL cold_data: got %h expected a1", d); end
    checks++; if (lat !== 7) begin errors++; $display("FAIL cold_latency: got %0d expected 7", lat); end
    checks++; if (ss !== 1'b0) begin errors++; $display("FAIL cold_store: got %b expected 0", ss); end
  endtask

  task automatic test_hit();
    logic [63:0] d, ca; int lat; bit m, bad, ss, em;
    em = model_access(64'h1038);
    do_fetch(64'h1038, 0, 0, d, lat, m, ca, bad, ss);
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL hit_timeout: got %b expected 0", bad); end
    checks++; if (m !== em) begin errors++; $display("FAIL hit_cmd_issued: got %b expected %b", m, em); end
    checks++; if (d !== 64'hA7) begin errors++; $display("FAIL hit_data: got %h expected a7", d); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL hit_latency: got %0d expected 2", lat); end
  endtask

  task automatic test_conflict();
    logic [63:0] d, ca; int lat; bit m, bad, ss, em;
    set_line(64'h2000, 64'hB0);
    em = model_access(64'h2000);
    do_fetch(64'h2000, 1, 2, d, lat, m, ca, bad, ss);
    checks++; if (m !== em || bad) begin errors++; $display("FAIL evict_miss: got miss=%b bad=%b expected miss=%b", m, bad, em); end
    checks++; if (d !== 64'hB0) begin errors++; $display("FAIL evict_data: got %h expected b0", d); end
    checks++; if (lat !== 7) begin errors++; $display("FAIL evict_latency: got %0d expected 7", lat); end
    em = model_access(64'h1000);
    do_fetch(64'h1000, 0, 1, d, lat, m, ca, bad, ss);
    checks++; if (m !== em || bad) begin errors++; $display("FAIL refetch_miss: got miss=%b bad=%b expected miss=%b", m, bad, em); end
    checks++; if (ca !== 64'h1000) begin errors++; $display("FAIL refetch_caddr: got %h expected 1000", ca); end
    checks++; if (d !== 64'hA0) begin errors++; $display("FAIL refetch_data: got %h expected a0", d); end
  endtask

  task automatic test_backpressure();
    int k; bit em;
    em = model_access(64'h1010);
    checks++; if (em !== 1'b0) begin errors++; $display("FAIL bp_model_resident: got miss=%b expected 0", em); end
    k = 0;
    while (req_ready !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    req_valid = 1'b1; req_addr = 64'h1010; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0;
    while (resp_valid !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    checks++; if (k !== 1) begin errors++; $display("FAIL bp_latency: got %0d expected 1 extra cycle", k); end
    checks++; if (resp_data !== 64'hA2) begin errors++; $display("FAIL bp_data: got %h expected a2", resp_data); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (resp_valid !== 1'b1 || resp_data !== 64'hA2) begin errors++; $display("FAIL bp_hold_%0d: got valid=%b data=%h expected 1/a2", i, resp_valid, resp_data); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready_%0d: got %b expected 0", i, req_ready); end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got valid=%b ready=%b expected 0/1", resp_valid, req_ready); end
  endtask

  task automatic test_reset_mid_miss();
    logic [63:0] d, ca; int lat, k; bit m, bad, ss, em;
    k = 0;
    while (req_ready !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    req_valid = 1'b1; req_addr = 64'h3040;
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0;
    while (command_valid !== 1'b1 && k < 10) begin @(posedge clk); #1; k++; end
    checks++; if (command_valid !== 1'b1 || command_addr !== 64'h3040) begin errors++; $display("FAIL midrst_cmd: got valid=%b addr=%h expected 1/3040", command_valid, command_addr); end
    bus_ready = 1'b1;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    checks++; if (command_rready !== 1'b1 || command_valid !== 1'b0) begin errors++; $display("FAIL midrst_wait: got rready=%b valid=%b expected 1/0", command_rready, command_valid); end
    reset = 1'b0; bus_valid = 1'b1; data_out = line_of(64'h3040);
    @(posedge clk); #1;
    checks++; if (command_rready !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL midrst_abandon: got rready=%b resp_valid=%b req_ready=%b expected 0/0/0", command_rready, resp_valid, req_ready); end
    reset = 1'b1; bus_valid = 1'b0;
    model_clear();
    em = model_access(64'h1000);
    do_fetch(64'h1000, 0, 0, d, lat, m, ca, bad, ss);
    checks++; if (m !== em || bad) begin errors++; $display("FAIL midrst_cold_1000: got miss=%b bad=%b expected miss=%b", m, bad, em); end
    checks++; if (d !== 64'hA0) begin errors++; $display("FAIL midrst_data_1000: got %h expected a0", d); end
    em = model_access(64'h3040);
    do_fetch(64'h3040, 0, 0, d, lat, m, ca, bad, ss);
    checks++; if (m !== em || bad) begin errors++; $display("FAIL midrst_not_installed: got miss=%b bad=%b expected miss=%b", m, bad, em); end
  endtask

  task automatic test_random();
    logic [63:0] a, d, ca, ed; logic [51:0] tg; logic [5:0] st;
    int lat, cd, rd, el; bit m, bad, ss, em;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: tg = 52'h1;
        1: tg = 52'h2;
        2: tg = 52'h8000000000001;
        default: tg = 52'hFFFFFFFFFFFFF;
      endcase
      case ($urandom_range(0, 3))
        0: st = 6'd0;
        1: st = 6'd1;
        2: st = 6'd63;
        default: st = 6'($urandom_range(0, 63));
      endcase
      a  = {tg, st, 3'($urandom_range(0, 7)), 3'($urandom)};
      cd = $urandom_range(0, 3);
      rd = $urandom_range(0, 3);
      em = model_access(a);
      ed = exp_word(a);
      el = em ? 4 + cd + rd : 2;
      do_fetch(a, cd, rd, d, lat, m, ca, bad, ss);
      checks++; if (bad !== 1'b0 || m !== em) begin errors++; $display("FAIL rnd_%0d_miss: addr=%h got miss=%b bad=%b expected miss=%b", n, a, m, bad, em); end
      checks++; if (d !== ed) begin errors++; $display("FAIL rnd_%0d_data: addr=%h got %h expected %h", n, a, d, ed); end
      checks++; if (lat !== el) begin errors++; $display("FAIL rnd_%0d_latency: got %0d expected %0d", n, lat, el); end
      if (em) begin
        checks++; if (ca !== (a & ~64'h3F)) begin errors++; $display("FAIL rnd_%0d_caddr: got %h expected %h", n, ca, a & ~64'h3F); end
      end
      checks++; if (ss !== 1'b0) begin errors++; $display("FAIL rnd_%0d_store: got %b expected 0", n, ss); end
    end
  endtask

`ifdef ICACHE_FLUSH_EN
  task automatic test_flush();
    logic [63:0] d, ca; int lat, k; bit m, bad, ss, em;
    em = model_access(64'h1000);
    do_fetch(64'h1000, 0, 0, d, lat, m, ca, bad, ss);
    checks++; if (bad || m !== em || d !== 64'hA0) begin errors++; $display("FAIL flush_prefill: got bad=%b miss=%b data=%h expected 0/%b/a0", bad, m, d, em); end
    k = 0;
    while (req_ready !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    flush_req = 1'b1; req_valid = 1'b1; req_addr = 64'h1000;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_req_ready: got %b expected 0", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (flush_done !== 1'b1) begin errors++; $display("FAIL flush_done_pulse: got %b expected 1", flush_done); end
    flush_req = 1'b0;
    @(posedge clk); #1;
    checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL flush_done_clear: got %b expected 0", flush_done); end
    model_clear();
    em = model_access(64'h1000);
    do_fetch(64'h1000, 0, 0, d, lat, m, ca, bad, ss);
    checks++; if (bad || m !== em || d !== 64'hA0) begin errors++; $display("FAIL flush_refetch: got bad=%b miss=%b data=%h expected 0/%b/a0", bad, m, d, em); end
  endtask
`endif

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_backpressure();
    test_reset_mid_miss();
    test_random();
`ifdef ICACHE_FLUSH_EN
    test_flush();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
